// File: rtl/traffic_light_if.sv
// Signal bundle between the intersection controller and its environment
// (1 s pulse source, pedestrian button, night switch, lamp drivers).
interface traffic_light_if;
    logic       tick;
    logic       ped_req;
    logic       night;
    logic [2:0] ns_light;
    logic [2:0] ew_light;
    logic [7:0] sec_left;
    logic       ped_walk;

    modport master (
        output tick, ped_req, night,
        input  ns_light, ew_light, sec_left, ped_walk
    );

    modport slave (
        input  tick, ped_req, night,
        output ns_light, ew_light, sec_left, ped_walk
    );
endinterface

// File: rtl/traffic_light_ctrl.sv
// Two-road (NS/EW) intersection controller: green/yellow/all-red sequencing with
// a seconds countdown, pedestrian-shortened greens and night flashing-yellow mode.
module traffic_light_ctrl #(
    parameter int unsigned T_GREEN  = 20,
    parameter int unsigned T_YELLOW = 3,
    parameter int unsigned T_ALLRED = 2,
    parameter int unsigned T_PED    = 5
) (
    input  logic           clk,
    input  logic           rst,
    traffic_light_if.slave bus
);
    localparam int unsigned SEC_W = 8;
    localparam logic [2:0]  RED   = 3'b100;
    localparam logic [2:0]  YEL   = 3'b010;
    localparam logic [2:0]  GRN   = 3'b001;
    localparam logic [2:0]  OFF   = 3'b000;

    typedef enum logic [2:0] {
        NS_GREEN, NS_YELLOW, ALL_RED1, EW_GREEN, EW_YELLOW, ALL_RED2, FLASH
    } state_t;

    state_t            state;
    logic [SEC_W-1:0]  sec_left;
    logic [2:0]        ns_light;
    logic [2:0]        ew_light;
    logic              ped_walk;
    logic              ped_pending;
    logic              flash_phase;

    function automatic state_t next_phase(input state_t s);
        case (s)
            NS_GREEN:  return NS_YELLOW;
            NS_YELLOW: return ALL_RED1;
            ALL_RED1:  return EW_GREEN;
            EW_GREEN:  return EW_YELLOW;
            EW_YELLOW: return ALL_RED2;
            default:   return NS_GREEN;
        endcase
    endfunction

    function automatic logic [SEC_W-1:0] duration(input state_t s);
        case (s)
            NS_GREEN, EW_GREEN:   return SEC_W'(T_GREEN);
            NS_YELLOW, EW_YELLOW: return SEC_W'(T_YELLOW);
            default:              return SEC_W'(T_ALLRED);
        endcase
    endfunction

    // {ns, ew} lamp pattern for the normal (non-flash) phases
    function automatic logic [5:0] lamps(input state_t s);
        case (s)
            NS_GREEN:  return {GRN, RED};
            NS_YELLOW: return {YEL, RED};
            EW_GREEN:  return {RED, GRN};
            EW_YELLOW: return {RED, YEL};
            default:   return {RED, RED};
        endcase
    endfunction

    function automatic logic is_all_red(input state_t s);
        return (s == ALL_RED1) || (s == ALL_RED2);
    endfunction

    logic   pending_c;
    logic   phase_end_c;
    logic   in_green_c;
    state_t adv_c;

    // A request seen this cycle counts immediately, so a green can clamp on the very next edge
    assign pending_c   = ped_pending | bus.ped_req;
    assign phase_end_c = bus.tick && (sec_left <= SEC_W'(1));
    assign in_green_c  = (state == NS_GREEN) || (state == EW_GREEN);
    assign adv_c       = next_phase(state);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ALL_RED2;
            sec_left    <= SEC_W'(T_ALLRED);
            ns_light    <= RED;
            ew_light    <= RED;
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
            flash_phase <= 1'b0;
        end else if (bus.night) begin
            // Night mode overrides everything; lamps blink on the seconds tick
            state       <= FLASH;
            sec_left    <= '0;
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
            if (state != FLASH) begin
                flash_phase <= 1'b1;
                ns_light    <= YEL;
                ew_light    <= YEL;
            end else if (bus.tick) begin
                flash_phase <= ~flash_phase;
                ns_light    <= flash_phase ? OFF : YEL;
                ew_light    <= flash_phase ? OFF : YEL;
            end
        end else if (state == FLASH) begin
            state       <= ALL_RED2;
            sec_left    <= SEC_W'(T_ALLRED);
            ns_light    <= RED;
            ew_light    <= RED;
            ped_walk    <= 1'b0;
            ped_pending <= 1'b0;
            flash_phase <= 1'b0;
        end else if (phase_end_c) begin
            state                <= adv_c;
            sec_left             <= duration(adv_c);
            {ns_light, ew_light} <= lamps(adv_c);
            // Leaving an all-red phase serves the request, including one arriving during it
            ped_pending          <= is_all_red(state) ? 1'b0 : pending_c;
            ped_walk             <= is_all_red(adv_c) && pending_c;
        end else begin
            ped_pending <= pending_c;
            ped_walk    <= is_all_red(state) && pending_c;
            if (bus.tick)
                sec_left <= sec_left - SEC_W'(1);
            else if (in_green_c && pending_c && (sec_left > SEC_W'(T_PED)))
                sec_left <= SEC_W'(T_PED);
        end
    end

    assign bus.ns_light = ns_light;
    assign bus.ew_light = ew_light;
    assign bus.sec_left = sec_left;
    assign bus.ped_walk = ped_walk;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Directed bench for traffic_light_ctrl: phase sequencing, countdown, pedestrian
// clamp/walk, night flashing, async reset, and a per-cycle cross-road safety check.
module tb_traffic_light_ctrl;
    localparam logic [2:0] RED = 3'b100;
    localparam logic [2:0] YEL = 3'b010;
    localparam logic [2:0] GRN = 3'b001;
    localparam logic [2:0] OFF = 3'b000;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    traffic_light_if bus();

    traffic_light_ctrl #(
        .T_GREEN (20),
        .T_YELLOW(3),
        .T_ALLRED(2),
        .T_PED   (5)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One second = one tick cycle followed by three idle cycles
    task automatic tick_n(input int n);
        for (int k = 0; k < n; k++) begin
            bus.tick = 1'b1;
            cyc(1);
            bus.tick = 1'b0;
            cyc(3);
        end
    endtask

    task automatic ped_pulse();
        bus.ped_req = 1'b1;
        cyc(1);
        bus.ped_req = 1'b0;
    endtask

    task automatic check_out(input string tag, input logic [2:0] ns, input logic [2:0] ew,
                             input int unsigned sec, input logic walk);
        chk({tag, ".ns"},   32'(bus.ns_light), 32'(ns));
        chk({tag, ".ew"},   32'(bus.ew_light), 32'(ew));
        chk({tag, ".sec"},  32'(bus.sec_left), sec);
        chk({tag, ".walk"}, 32'(bus.ped_walk), 32'(walk));
    endtask

    // No green facing green or yellow on the crossing road, lamps one-hot or dark
    always @(negedge clk) begin
        logic bad;
        bad = (bus.ns_light[0] && (bus.ew_light[0] || bus.ew_light[1]))
           || (bus.ew_light[0] && bus.ns_light[1])
           || ($countones(bus.ns_light) > 1) || ($countones(bus.ew_light) > 1);
        chk("cross_road", 32'(bad), 0);
    end

    initial begin
        rst         = 1'b1;
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
        bus.night   = 1'b0;
        cyc(2);
        check_out("reset", RED, RED, 2, 1'b0);
        rst = 1'b0;
        cyc(1);
        check_out("post_reset", RED, RED, 2, 1'b0);
        tick_n(1);
        chk("allred2_cnt", 32'(bus.sec_left), 1);
        tick_n(1);
        check_out("ns_green", GRN, RED, 20, 1'b0);

        for (int i = 19; i >= 1; i--) begin
            tick_n(1);
            chk("countdown", 32'(bus.sec_left), i);
        end
        cyc(100);
        chk("hold_no_tick", 32'(bus.sec_left), 1);
        tick_n(1);
        check_out("ns_yellow", YEL, RED, 3, 1'b0);
        tick_n(3);
        check_out("all_red1", RED, RED, 2, 1'b0);
        tick_n(2);
        check_out("ew_green", RED, GRN, 20, 1'b0);
        tick_n(20);
        check_out("ew_yellow", RED, YEL, 3, 1'b0);
        tick_n(3);
        check_out("all_red2", RED, RED, 2, 1'b0);
        tick_n(2);
        check_out("ns_green2", GRN, RED, 20, 1'b0);

        // Pedestrian request shortens NS green, walk served in ALL_RED1
        tick_n(5);
        chk("pre_ped", 32'(bus.sec_left), 15);
        ped_pulse();
        chk("ped_clamp", 32'(bus.sec_left), 5);
        tick_n(4);
        check_out("clamped_end", GRN, RED, 1, 1'b0);
        tick_n(1);
        check_out("ped_yellow", YEL, RED, 3, 1'b0);
        tick_n(3);
        check_out("walk_ar1", RED, RED, 2, 1'b1);
        tick_n(1);
        check_out("walk_ar1b", RED, RED, 1, 1'b1);
        tick_n(1);
        check_out("walk_done", RED, GRN, 20, 1'b0);
        cyc(3);
        chk("pending_clear", 32'(bus.sec_left), 20);

        // Late request: no clamp, walk served in ALL_RED2
        tick_n(17);
        chk("ew_late", 32'(bus.sec_left), 3);
        ped_pulse();
        chk("no_clamp", 32'(bus.sec_left), 3);
        tick_n(3);
        check_out("late_yellow", RED, YEL, 3, 1'b0);
        tick_n(3);
        check_out("walk_ar2", RED, RED, 2, 1'b1);
        tick_n(2);
        check_out("walk2_done", GRN, RED, 20, 1'b0);

        // Request coinciding with a tick: decrement first, clamp next cycle
        tick_n(10);
        chk("pre_coinc", 32'(bus.sec_left), 10);
        bus.tick    = 1'b1;
        bus.ped_req = 1'b1;
        cyc(1);
        bus.tick    = 1'b0;
        bus.ped_req = 1'b0;
        chk("coinc_tick", 32'(bus.sec_left), 9);
        cyc(1);
        chk("coinc_clamp", 32'(bus.sec_left), 5);
        cyc(2);
        tick_n(5);
        check_out("coinc_yellow", YEL, RED, 3, 1'b0);
        tick_n(3);
        check_out("coinc_walk", RED, RED, 2, 1'b1);
        tick_n(2);
        tick_n(20);
        check_out("ew_yellow2", RED, YEL, 3, 1'b0);
        tick_n(1);
        chk("ew_yellow2_cnt", 32'(bus.sec_left), 2);

        // Night flashing mode
        bus.night = 1'b1;
        cyc(1);
        check_out("flash_entry", YEL, YEL, 0, 1'b0);
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        check_out("flash_off", OFF, OFF, 0, 1'b0);
        cyc(3);
        tick_n(1);
        check_out("flash_on", YEL, YEL, 0, 1'b0);
        ped_pulse();
        tick_n(1);
        check_out("flash_off2", OFF, OFF, 0, 1'b0);
        bus.night = 1'b0;
        cyc(1);
        check_out("night_exit", RED, RED, 2, 1'b0);
        tick_n(1);
        check_out("flash_ped_ignored", RED, RED, 1, 1'b0);
        tick_n(1);
        check_out("after_night", GRN, RED, 20, 1'b0);

        // Asynchronous reset between clock edges
        tick_n(20);
        check_out("ns_yellow3", YEL, RED, 3, 1'b0);
        tick_n(1);
        chk("pre_reset", 32'(bus.sec_left), 2);
        #2 rst = 1'b1;
        #1 check_out("async_reset", RED, RED, 2, 1'b0);
        @(negedge clk);
        bus.tick = 1'b1;
        cyc(1);
        bus.tick = 1'b0;
        check_out("reset_holds", RED, RED, 2, 1'b0);
        rst = 1'b0;
        cyc(1);
        check_out("reset_release", RED, RED, 2, 1'b0);
        tick_n(2);
        check_out("restart_green", GRN, RED, 20, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
